// File: rtl/branch_pkg.sv
// Shared constants, types and helpers for the branch resolve unit.
// Gshare indexing is enabled with the BRANCH_GSHARE_EN macro.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_LT,
    CMP_LTU
  } cmp_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] cur,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST)
        nxt = cur + 2'd1;
    end else begin
      if (cur != CNT_SNT)
        nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Conditional branch comparator at full XLEN width.
// Flags whether the ID instruction is a resolvable branch.
module branch_cond_eval #(
  parameter int XLEN = 32
) (
  input  logic            valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            is_cond_branch
);
  import branch_pkg::*;

  logic eq;
  logic lt;
  logic ltu;
  logic f3_ok;
  logic negate;
  logic raw;
  cmp_t cmp;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  // Decode funct3 into a base compare plus an inversion.
  always_comb begin
    cmp    = CMP_EQ;
    negate = 1'b0;
    f3_ok  = 1'b0;
    unique case (funct3)
      F3_BEQ: begin
        f3_ok = 1'b1;
      end
      F3_BNE: begin
        f3_ok  = 1'b1;
        negate = 1'b1;
      end
      F3_BLT: begin
        f3_ok = 1'b1;
        cmp   = CMP_LT;
      end
      F3_BGE: begin
        f3_ok  = 1'b1;
        cmp    = CMP_LT;
        negate = 1'b1;
      end
      F3_BLTU: begin
        f3_ok = 1'b1;
        cmp   = CMP_LTU;
      end
      F3_BGEU: begin
        f3_ok  = 1'b1;
        cmp    = CMP_LTU;
        negate = 1'b1;
      end
      default: begin
        f3_ok = 1'b0;
      end
    endcase
  end

  // Select the compare result and gate it with branch validity.
  always_comb begin
    raw = eq;
    unique case (cmp)
      CMP_LT:  raw = lt;
      CMP_LTU: raw = ltu;
      default: raw = eq;
    endcase
    is_cond_branch = valid
                   & (opcode == OPC_BRANCH)
                   & f3_ok;
    taken = is_cond_branch & (raw ^ negate);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch prediction table, ID-stage resolution and statistics.
// Define BRANCH_GSHARE_EN to XOR global history into the index.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int GHR_W     = 6,
  parameter int STAT_W    = 32,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  input  logic              res_valid_i,
  input  logic [6:0]        res_opcode_i,
  input  logic [2:0]        res_funct3_i,
  input  logic [XLEN-1:0]   res_rs1_i,
  input  logic [XLEN-1:0]   res_rs2_i,
  input  logic [IDX_W-1:0]  res_idx_i,
  input  logic              res_pred_i,
  output logic              res_taken_o,
  output logic              res_mispredict_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  logic [1:0]       bht [BHT_DEPTH];
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             res_is_br;
  logic [IDX_W-1:0] pc_idx;
  logic             unused_pc;

  assign pc_idx    = pred_pc_i[IDX_W+1:2];
  assign unused_pc = ^{pred_pc_i[XLEN-1:IDX_W+2],
                       pred_pc_i[1:0]};

`ifdef BRANCH_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign pred_idx_o = pc_idx ^ IDX_W'(ghr);

  // Shift the actual outcome into history on every resolved branch.
  always_ff @(posedge clk) begin
    if (rst)
      ghr <= '0;
    else if (res_is_br)
      ghr <= {ghr[GHR_W-2:0], res_taken_o};
  end
`else
  assign pred_idx_o = pc_idx;
`endif

  assign pred_taken_o = bht[pred_idx_o][1];

  branch_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .valid          (res_valid_i),
    .opcode         (res_opcode_i),
    .funct3         (res_funct3_i),
    .rs1            (res_rs1_i),
    .rs2            (res_rs2_i),
    .taken          (res_taken_o),
    .is_cond_branch (res_is_br)
  );

  assign res_mispredict_o = res_is_br
                          & (res_taken_o ^ res_pred_i);

  // Capture the outcome so training happens one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_taken <= 1'b0;
    end else begin
      upd_valid <= res_is_br;
      upd_idx   <= res_idx_i;
      upd_taken <= res_taken_o;
    end
  end

  // Counter table; reset wins over a pending training write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= CNT_WNT;
    end else if (upd_valid) begin
      bht[upd_idx] <= ctr_next(bht[upd_idx], upd_taken);
    end
  end

  // Saturating branch and mispredict totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (res_is_br) begin
      if (branch_cnt_o != '1)
        branch_cnt_o <= branch_cnt_o + STAT_W'(1);
      if (res_mispredict_o && (mispred_cnt_o != '1))
        mispred_cnt_o <= mispred_cnt_o + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 64;
  localparam int GHRW  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken_o;
  logic [5:0]  pred_idx_o;
  logic        res_valid;
  logic [6:0]  res_opcode;
  logic [2:0]  res_funct3;
  logic [31:0] res_rs1;
  logic [31:0] res_rs2;
  logic [5:0]  res_idx;
  logic        res_pred;
  logic        res_taken_o;
  logic        res_mis_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks   = 0;
  int failures = 0;

  int     bht_m [DEPTH];
  int     pend_v;
  int     pend_idx;
  int     pend_t;
  longint bcnt;
  longint mcnt;
  int     ghr_m;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        p;
    logic        et;
    logic        em;
  } vec_t;

  vec_t vecs [12];

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .pred_pc_i        (pred_pc),
    .pred_taken_o     (pred_taken_o),
    .pred_idx_o       (pred_idx_o),
    .res_valid_i      (res_valid),
    .res_opcode_i     (res_opcode),
    .res_funct3_i     (res_funct3),
    .res_rs1_i        (res_rs1),
    .res_rs2_i        (res_rs2),
    .res_idx_i        (res_idx),
    .res_pred_i       (res_pred),
    .res_taken_o      (res_taken_o),
    .res_mispredict_o (res_mis_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) & (DEPTH - 1));
`ifdef BRANCH_GSHARE_EN
    idx = idx ^ ghr_m;
`endif
    return idx;
  endfunction

  task automatic m_resolve(input  logic        v,
                           input  logic [6:0]  op,
                           input  logic [2:0]  f3,
                           input  logic [31:0] a,
                           input  logic [31:0] b,
                           output logic        isbr,
                           output logic        t);
    isbr = v && (op == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
    case (f3)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = ($signed(a) < $signed(b));
      3'd5:    t = ($signed(a) >= $signed(b));
      3'd6:    t = (a < b);
      3'd7:    t = (a >= b);
      default: t = 1'b0;
    endcase
    t = t && isbr;
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++)
      bht_m[i] = 1;
    pend_v = 0;
    pend_idx = 0;
    pend_t = 0;
    bcnt = 0;
    mcnt = 0;
    ghr_m = 0;
  endtask

  // One cycle: compare everything, then advance the model on the edge.
  task automatic tick();
    int   idx;
    logic ebr;
    logic et;
    logic em;
    #1;
    idx = m_index(pred_pc);
    m_resolve(res_valid, res_opcode, res_funct3,
              res_rs1, res_rs2, ebr, et);
    em = ebr && (et != res_pred);
    chk("pred_idx", 64'(pred_idx_o), 64'(idx));
    chk("pred_taken", 64'(pred_taken_o), 64'(bht_m[idx] >= 2));
    chk("res_taken", 64'(res_taken_o), 64'(et));
    chk("mispredict", 64'(res_mis_o), 64'(em));
    chk("branch_cnt", 64'(branch_cnt_o), bcnt);
    chk("mispred_cnt", 64'(mispred_cnt_o), mcnt);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (pend_v != 0) begin
        if (pend_t != 0)
          bht_m[pend_idx] = (bht_m[pend_idx] < 3) ?
                            bht_m[pend_idx] + 1 : 3;
        else
          bht_m[pend_idx] = (bht_m[pend_idx] > 0) ?
                            bht_m[pend_idx] - 1 : 0;
      end
      pend_v   = ebr ? 1 : 0;
      pend_idx = int'(res_idx);
      pend_t   = et ? 1 : 0;
      if (ebr) begin
        if (bcnt < 64'hFFFF_FFFF) bcnt++;
        if (em && mcnt < 64'hFFFF_FFFF) mcnt++;
        ghr_m = ((ghr_m << 1) | (et ? 1 : 0)) & ((1 << GHRW) - 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_res(input logic        v,
                         input logic [6:0]  op,
                         input logic [2:0]  f3,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic        p);
    res_valid  = v;
    res_opcode = op;
    res_funct3 = f3;
    res_rs1    = a;
    res_rs2    = b;
    res_pred   = p;
  endtask

  initial begin
    vecs[0]  = '{1, 7'h63, 3'd4, 32'hFFFFFFFF, 32'h1, 0, 1, 1};
    vecs[1]  = '{1, 7'h63, 3'd6, 32'hFFFFFFFF, 32'h1, 0, 0, 0};
    vecs[2]  = '{1, 7'h63, 3'd0, 32'h5, 32'h5, 1, 1, 0};
    vecs[3]  = '{1, 7'h63, 3'd1, 32'h5, 32'h5, 1, 0, 1};
    vecs[4]  = '{1, 7'h63, 3'd5, 32'h1, 32'hFFFFFFFF, 0, 1, 1};
    vecs[5]  = '{1, 7'h63, 3'd7, 32'h1, 32'hFFFFFFFF, 0, 0, 0};
    vecs[6]  = '{1, 7'h63, 3'd2, 32'h5, 32'h5, 0, 0, 0};
    vecs[7]  = '{1, 7'h63, 3'd3, 32'h5, 32'h5, 1, 0, 0};
    vecs[8]  = '{0, 7'h63, 3'd0, 32'h5, 32'h5, 1, 0, 0};
    vecs[9]  = '{1, 7'h67, 3'd0, 32'h5, 32'h5, 1, 0, 0};
    vecs[10] = '{1, 7'h63, 3'd4, 32'h80000000, 32'h7FFFFFFF, 1, 1, 0};
    vecs[11] = '{1, 7'h63, 3'd7, 32'h80000000, 32'h7FFFFFFF, 0, 1, 1};

    rst = 1'b1;
    pred_pc = 32'h100;
    res_idx = '0;
    set_res(0, 7'h0, 3'd0, 0, 0, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state.
    #1;
    chk("reset_pred_taken", 64'(pred_taken_o), 64'd0);
    chk("reset_branch_cnt", 64'(branch_cnt_o), 64'd0);
    chk("reset_mispred_cnt", 64'(mispred_cnt_o), 64'd0);
    tick();
    rst = 1'b0;

    // Three taken BEQs on one index, predicted not-taken.
    pred_pc = 32'h104;
    res_idx = 6'(m_index(pred_pc));
    set_res(1, 7'h63, 3'd0, 32'h7, 32'h7, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        set_res(0, 7'h63, 3'd0, 32'h7, 32'h7, 0);
      end
`ifndef BRANCH_GSHARE_EN
      #1;
      chk("beq_seq_pred", 64'(pred_taken_o), 64'(c >= 2));
`endif
      res_idx = 6'(m_index(pred_pc));
      tick();
    end
    #1;
    chk("beq_seq_branch_cnt", 64'(branch_cnt_o), 64'd3);
    chk("beq_seq_mispred_cnt", 64'(mispred_cnt_o), 64'd3);

    // Combinational resolution vectors.
    pred_pc = 32'h10C;
    for (int i = 0; i < 12; i++) begin
      set_res(vecs[i].v, vecs[i].op, vecs[i].f3,
              vecs[i].a, vecs[i].b, vecs[i].p);
      res_idx = 6'd3;
      #1;
      chk($sformatf("vec%0d_taken", i), 64'(res_taken_o),
          64'(vecs[i].et));
      chk($sformatf("vec%0d_mis", i), 64'(res_mis_o),
          64'(vecs[i].em));
      tick();
    end

    // Reset the cycle after a resolve drops the pending update.
    set_res(0, 7'h63, 3'd0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pred_pc = 32'h108;
    res_idx = 6'(m_index(pred_pc));
    set_res(1, 7'h63, 3'd0, 32'h9, 32'h9, 1);
    tick();
    set_res(0, 7'h63, 3'd0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("rst_drop_pred", 64'(pred_taken_o), 64'd0);
    chk("rst_drop_cnt", 64'(branch_cnt_o), 64'd0);

`ifdef BRANCH_GSHARE_EN
    // History T, NT, T folds into the index.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_res(1, 7'h63, 3'd0, 32'h1, 32'h1, 0);
    tick();
    set_res(1, 7'h63, 3'd0, 32'h1, 32'h2, 0);
    tick();
    set_res(1, 7'h63, 3'd0, 32'h1, 32'h1, 0);
    tick();
    set_res(0, 7'h63, 3'd0, 0, 0, 0);
    pred_pc = 32'h100;
    #1;
    chk("gshare_idx", 64'(pred_idx_o), 64'd5);
    tick();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      rst = ($urandom_range(0, 59) == 0);
      pred_pc = ($urandom & 32'hFFFF_F000)
              | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 0) ? $urandom
                                      : 32'($urandom_range(0, 4));
      set_res($urandom_range(0, 9) != 0,
              ($urandom_range(0, 4) != 0) ? 7'h63 : 7'($urandom),
              3'($urandom),
              a,
              ($urandom_range(0, 2) == 0) ? a :
                (($urandom_range(0, 1) == 0) ? $urandom
                                             : 32'($urandom_range(0, 4))),
              1'($urandom));
      res_idx = ($urandom_range(0, 1) == 0) ?
                6'(m_index(pred_pc)) : 6'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and dynamic prediction block for the pipelined core. It sits between IF and ID. IF gets a combinational taken/not-taken prediction from a table of saturating counters. ID resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) at XLEN width, flags mispredictions and trains the table one cycle later. Saturating statistics counters expose branch and mispredict totals.

## Interface
- XLEN, 32, operand and PC width
- BHT_DEPTH, 64, counter table entries; power of two, ≥ 4; IDX_W = log2(BHT_DEPTH)
- GHR_W, 6, global history width; used only with gshare; must be ≤ IDX_W
- STAT_W, 32, statistics counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pred_pc_i  in  XLEN  fetch PC
- pred_taken_o  out  1  prediction, combinational from the table
- pred_idx_o  out  IDX_W  table index used; the pipeline carries it down to ID
- res_valid_i  in  1  ID holds a valid instruction this cycle
- res_opcode_i  in  7  instruction opcode
- res_funct3_i  in  3  instruction funct3
- res_rs1_i, res_rs2_i  in  XLEN  forwarded operands
- res_idx_i  in  IDX_W  index carried from fetch
- res_pred_i  in  1  prediction carried from fetch
- res_taken_o  out  1  resolved outcome, combinational
- res_mispredict_o  out  1  outcome differs from res_pred_i, combinational
- branch_cnt_o  out  STAT_W  resolved conditional branches
- mispred_cnt_o  out  STAT_W  mispredictions

## Operation
- Table: BHT_DEPTH 2-bit counters. 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T.
- Prediction: pred_taken_o = counter[pred_idx_o][1].
  - Base index: pred_pc_i[IDX_W+1:2].
- Resolution is valid only when res_valid_i=1, res_opcode_i = 7'b1100011, and funct3 ∈ {000,001,100,101,110,111}.
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Full XLEN compare.
- When resolution is not valid (including funct3 010 or 011):
  - res_taken_o=0 and res_mispredict_o=0.
  - No table update, no GHR update, no count.
- res_mispredict_o = res_taken_o XOR res_pred_i.
- Training on a valid resolution:
  - Latch {res_idx_i, res_taken_o} into one update register.
  - On the next edge, counter[idx] increments if taken, otherwise decrements, saturating at 11 and 00.
- Back-to-back resolutions pipeline one per cycle. Each resolution trains exactly once.
- Statistics:
  - branch_cnt_o increments on each valid resolution.
  - mispred_cnt_o also increments when res_mispredict_o=1.
  - Both saturate at all-ones.

## Timing
- Prediction and resolution outputs: 0-cycle latency, combinational.
- Table write lands 2 edges after the resolve cycle: latch edge, then write edge.
- Statistics counters update on the edge that ends the resolve cycle.
- Read during write to the same index: the prediction sees the pre-write value. No bypass.
- Reset:
  - All counters to 01. GHR to 0. Update register invalid. Both statistics counters to 0.
  - pred_taken_o therefore reads 0 after reset.
- Reset mid-operation: a pending update is discarded. Reset takes priority over every update in the same cycle.

## Configuration
- BRANCH_GSHARE_EN
- Defined:
  - pred_idx_o = pred_pc_i[IDX_W+1:2] XOR {zero-extend, GHR}.
  - GHR shifts in res_taken_o (LSB) on each valid resolution, on the resolve edge.
  - A mispredict still shifts in the actual outcome. There is no repair beyond that.
- Undefined: no GHR register; the index is the PC bits only; GHR_W is ignored.

## Structure
- Package branch_pkg:
  - OPC_BRANCH = 7'b1100011.
  - funct3 constants F3_BEQ … F3_BGEU.
  - 2-bit counter state constants.
  - Counter saturating-update function.
- Sub-module branch_cond_eval: parametrised XLEN comparator. Outputs taken and is_cond_branch.
- The table is a register array: no RAM macro, reset-initialised.

## Test plan
- Reset, then pred_pc_i=0x100 → pred_taken_o=0; branch_cnt_o=0 and mispred_cnt_o=0.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred=0 → taken=1, mispredict=1. BLTU with the same operands → taken=0, mispredict=0.
- Three taken BEQs at the same idx on consecutive cycles → counter goes 01→10→11→11. pred_taken_o=1 from 2 cycles after the first; mispred_cnt_o=3 when pred=0.
- opcode 0x63 with funct3=010, or res_valid_i=0 → taken=0, mispredict=0, counters and table unchanged.
- Assert rst the cycle after a resolve → pending update dropped; table entry reads 01.
- With BRANCH_GSHARE_EN: after resolving T, NT, T, pred_pc_i=0x100 → pred_idx_o = 0x00 XOR 0b101 = 5.
